multdiv_ctrl: RTL and testbench
===============================

# multdiv_ctrl

Sequencer for a multicycle signed 32-bit multiply/divide unit. It shares one externally instantiated 32-bit carry-lookahead adder, driving its operands and carry-in every cycle and consuming its sum and carry-out. Multiply uses radix-2 Booth iteration. Divide uses restoring iteration on operand magnitudes. It sits beside the main ALU and is started by one-cycle control pulses from the pipeline.

## Interface
- No parameters; width fixed at 32.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_operandA`  in  32  multiplicand / dividend, signed; sampled on the start edge.
- `data_operandB`  in  32  multiplier / divisor, signed; sampled on the start edge.
- `ctrl_MULT`  in  1  start-multiply pulse.
- `ctrl_DIV`  in  1  start-divide pulse.
- `data_result`  out  32  registered result.
- `data_exception`  out  1  registered overflow or divide-by-zero flag.
- `data_resultRDY`  out  1  one-cycle completion pulse.
- `add_A`  out  32  adder operand A (combinational from state).
- `add_B`  out  32  adder operand B.
- `add_Cin`  out  1  adder carry-in.
- `add_S`  in  32  adder sum.
- `add_Cout`  in  1  adder carry-out.

## Operation
States: IDLE, M_ITER, D_ABSA, D_ABSB, D_ITER, D_SIGN, DONE. A 5-bit iteration counter runs 0..31.

**Start**
- A start edge is any edge with `ctrl_MULT` or `ctrl_DIV` high.
- Start is accepted in any state; a running operation is aborted and restarted.
- If both are high, the operation is MULT.

**Multiply**
- On the start edge: hi←0, lo←A, q←0, M←B; go to M_ITER.
- Each M_ITER cycle selects the adder inputs from {lo[0], q}:
  - 01: add_A=hi, add_B=M, add_Cin=0.
  - 10: add_A=hi, add_B=~M, add_Cin=1.
  - 00 or 11: add_A=hi, add_B=0, add_Cin=0.
- Overflow V = (add_A[31]==add_B[31]) && (add_S[31]!=add_A[31]).
- Shift: {hi,lo,q} ← arithmetic right shift of {add_S,lo,q}, with shifted-in MSB = add_S[31]^V.
- After count 31: data_result←lo; data_exception←(hi != {32{lo[31]}}); go to DONE.

**Divide**
- On the start edge, if B==0: data_result←0, data_exception←1, go to DONE.
- Otherwise latch sA=A[31] and sB=B[31].
- D_ABSA: add_A=~A, add_B=0, add_Cin=1. Q←(sA ? add_S : A).
- D_ABSB: same negation on B. D←|B|, R←0.
- D_ITER, per cycle:
  - R'={R[30:0],Q[31]}; add_A=R', add_B=~D, add_Cin=1.
  - If add_Cout=1: R←add_S, Q←{Q[30:0],1}.
  - Else: R←R', Q←{Q[30:0],0}.
- D_SIGN: add_A=~Q, add_B=0, add_Cin=1.
  - data_result←(sA^sB) ? add_S : Q.
  - data_exception←(sA^sB)==0 && Q[31]. This covers 0x80000000 / -1; the result is then forced to 0.
- Quotient truncates toward zero; the remainder is discarded.

**Other states**
- DONE: data_resultRDY=1 for one cycle, then IDLE.
- In IDLE and DONE: add_A=0, add_B=0, add_Cin=0.
- data_result and data_exception hold until the next completion. They are not cleared on start.

## Timing
- Reset (async, active low): state=IDLE, counter=0, all internal registers 0.
- Reset values of outputs: data_result=0, data_exception=0, data_resultRDY=0, add_A=0, add_B=0, add_Cin=0.
- Reset asserted mid-operation aborts with no RDY pulse.
- Let the start edge be k. data_resultRDY is high in the cycle following:
  - MULT: edge k+32.
  - DIV: edge k+35.
  - Divide by zero: edge k+1.
- data_result and data_exception are valid on that same cycle.
- The adder path is combinational within one cycle; all state updates occur on `clock` rising edges.
- A start in the DONE cycle is honoured; RDY still pulses for the completing operation.

## Test plan
- MULT 6 × -7 → data_result=0xFFFFFFD6, data_exception=0, RDY in the cycle after edge k+32 only.
- MULT 0x00010000 × 0x00010000 → data_result=0x00000000, data_exception=1. MULT 0x80000000 × 1 → 0x80000000, data_exception=0.
- DIV -7 / 2 → 0xFFFFFFFD, data_exception=0, RDY after edge k+35. DIV 100 / 7 → 14.
- DIV 100 / 0 → data_result=0, data_exception=1, RDY after edge k+1. DIV 0x80000000 / -1 → data_exception=1, data_result=0.
- Restart: ctrl_DIV 100/7, then ctrl_MULT 3×5 at k+10 → single RDY after edge k+42, data_result=15.
- Drop reset_n at k+5 of a MULT → all outputs 0 immediately, no RDY. A new start after release completes normally.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Sequencer for a multicycle signed 32-bit multiply/divide unit sharing one external
// 32-bit adder: radix-2 Booth multiply and restoring divide on operand magnitudes.
module multdiv_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic [31:0] add_A,
    output logic [31:0] add_B,
    output logic        add_Cin,
    input  logic [31:0] add_S,
    input  logic        add_Cout
);

    typedef enum logic [2:0] {
        IDLE, M_ITER, D_ABSA, D_ABSB, D_ITER, D_SIGN, DONE
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mreg;
    logic        qbit;
    logic        sa;
    logic        sb;
    logic        dz;

    logic        ovf;
    logic [31:0] rshift;
    logic [31:0] mhi_next;
    logic [31:0] mlo_next;

    // hi/lo double as remainder/quotient during divide; mreg holds multiplicand or divisor.
    always_comb begin
        add_A   = '0;
        add_B   = '0;
        add_Cin = 1'b0;
        rshift  = {hi[30:0], lo[31]};
        case (state)
            M_ITER: begin
                add_A = hi;
                case ({lo[0], qbit})
                    2'b01:   add_B = mreg;
                    2'b10: begin
                        add_B   = ~mreg;
                        add_Cin = 1'b1;
                    end
                    default: add_B = '0;
                endcase
            end
            D_ABSA: begin
                add_A   = ~lo;
                add_Cin = 1'b1;
            end
            D_ABSB: begin
                add_A   = ~mreg;
                add_Cin = 1'b1;
            end
            D_ITER: begin
                add_A   = rshift;
                add_B   = ~mreg;
                add_Cin = 1'b1;
            end
            D_SIGN: begin
                add_A   = ~lo;
                add_Cin = 1'b1;
            end
            default: begin
                add_A   = '0;
                add_B   = '0;
                add_Cin = 1'b0;
            end
        endcase
    end

    // Overflow-corrected sign keeps the arithmetic shift exact when hi +/- M overflows.
    assign ovf      = (add_A[31] == add_B[31]) && (add_S[31] != add_A[31]);
    assign mhi_next = {add_S[31] ^ ovf, add_S[31:1]};
    assign mlo_next = {add_S[0], lo[31:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            hi             <= '0;
            lo             <= '0;
            mreg           <= '0;
            qbit           <= 1'b0;
            sa             <= 1'b0;
            sb             <= 1'b0;
            dz             <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                hi    <= '0;
                lo    <= data_operandA;
                qbit  <= 1'b0;
                mreg  <= data_operandB;
                count <= '0;
                state <= M_ITER;
            end else if (ctrl_DIV) begin
                hi    <= '0;
                lo    <= data_operandA;
                mreg  <= data_operandB;
                count <= '0;
                sa    <= data_operandA[31];
                sb    <= data_operandB[31];
                dz    <= (data_operandB == 32'd0);
                state <= (data_operandB == 32'd0) ? D_SIGN : D_ABSA;
            end else begin
                case (state)
                    M_ITER: begin
                        hi    <= mhi_next;
                        lo    <= mlo_next;
                        qbit  <= lo[0];
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            data_result    <= mlo_next;
                            data_exception <= (mhi_next != {32{mlo_next[31]}});
                            data_resultRDY <= 1'b1;
                            state          <= DONE;
                        end
                    end
                    D_ABSA: begin
                        if (sa) lo <= add_S;
                        state <= D_ABSB;
                    end
                    D_ABSB: begin
                        if (sb) mreg <= add_S;
                        hi    <= '0;
                        count <= '0;
                        state <= D_ITER;
                    end
                    D_ITER: begin
                        if (add_Cout) begin
                            hi <= add_S;
                            lo <= {lo[30:0], 1'b1};
                        end else begin
                            hi <= rshift;
                            lo <= {lo[30:0], 1'b0};
                        end
                        count <= count + 5'd1;
                        if (count == 5'd31) state <= D_SIGN;
                    end
                    D_SIGN: begin
                        // A same-sign quotient with bit 31 set can only be 0x80000000 / -1.
                        if (dz) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                        end else if (sa ^ sb) begin
                            data_result    <= add_S;
                            data_exception <= 1'b0;
                        end else begin
                            data_result    <= lo[31] ? 32'd0 : lo;
                            data_exception <= lo[31];
                        end
                        data_resultRDY <= 1'b1;
                        state          <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus pushes expected results with their cycle
// of arrival, and a monitor pops and compares on every completion pulse.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [31:0] add_A;
    logic [31:0] add_B;
    logic        add_Cin;
    logic [31:0] add_S;
    logic        add_Cout;

    multdiv_ctrl dut (
        .clock(clock),
        .reset_n(reset_n),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .add_A(add_A),
        .add_B(add_B),
        .add_Cin(add_Cin),
        .add_S(add_S),
        .add_Cout(add_Cout)
    );

    // Stand-in for the shared external adder
    assign {add_Cout, add_S} = {1'b0, add_A} + {1'b0, add_B} + {32'd0, add_Cin};

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        exc;
        int          at;
    } exp_t;

    typedef struct {
        string       name;
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
        int          lat;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[$];
    int   nChecks = 0;
    int   nFails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        exp_t e;
        if (reset_n === 1'b1 && data_resultRDY === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_rdy: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput({e.name, "_result"}, data_result, e.res);
                checkOutput({e.name, "_exception"}, {31'd0, data_exception}, {31'd0, e.exc});
                checkOutput({e.name, "_cycle"}, cyc, e.at);
            end
        end
    end

    // Called at a falling edge; the start is sampled on the following rising edge k.
    task automatic applyStimulus(input string name, input bit m, input bit d,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] res, input bit exc, input int lat,
                                 input bit expectDone, output int k);
        exp_t e;
        k             = cyc + 1;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        if (expectDone) begin
            e.name = name;
            e.res  = res;
            e.exc  = exc;
            e.at   = k + lat;
            expQ.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic waitToCyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic waitDrain(input int budget);
        int t = 0;
        while (expQ.size() > 0 && t < budget) begin
            @(negedge clock);
            t++;
        end
        if (expQ.size() > 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL timeout: got %0d results outstanding, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_result"}, data_result, 32'd0);
        checkOutput({tag, "_exception"}, {31'd0, data_exception}, 32'd0);
        checkOutput({tag, "_rdy"}, {31'd0, data_resultRDY}, 32'd0);
        checkOutput({tag, "_addA"}, add_A, 32'd0);
        checkOutput({tag, "_addB"}, add_B, 32'd0);
        checkOutput({tag, "_addCin"}, {31'd0, add_Cin}, 32'd0);
    endtask

    initial begin
        int k;
        int k2;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;

        vecs.push_back('{"mul_6_x_m7",       1, 0, 32'd6,        32'hFFFFFFF9, 32'hFFFFFFD6, 0, 32});
        vecs.push_back('{"mul_ovf_2p32",     1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1, 32});
        vecs.push_back('{"mul_min_x_1",      1, 0, 32'h80000000, 32'd1,        32'h80000000, 0, 32});
        vecs.push_back('{"mul_max_x_2",      1, 0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1, 32});
        vecs.push_back('{"mul_m1_x_m1",      1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        0, 32});
        vecs.push_back('{"mul_both_ctrl",    1, 1, 32'd3,        32'd5,        32'd15,       0, 32});
        vecs.push_back('{"div_m7_by_2",      0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 35});
        vecs.push_back('{"div_100_by_7",     0, 1, 32'd100,      32'd7,        32'd14,       0, 35});
        vecs.push_back('{"div_m100_by_7",    0, 1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 0, 35});
        vecs.push_back('{"div_7_by_m2",      0, 1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 35});
        vecs.push_back('{"div_by_zero",      0, 1, 32'd100,      32'd0,        32'd0,        1, 1});
        vecs.push_back('{"div_min_by_m1",    0, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 35});
        vecs.push_back('{"div_min_by_1",     0, 1, 32'h80000000, 32'd1,        32'h80000000, 0, 35});

        #2;
        checkAllZero("reset");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].name, vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                          vecs[i].res, vecs[i].exc, vecs[i].lat, 1'b1, k);
            waitDrain(200);
        end

        // Restart: a multiply issued mid-divide replaces it with a single completion
        applyStimulus("restart_div", 0, 1, 32'd100, 32'd7, 32'd14, 0, 35, 1'b0, k);
        waitToCyc(k + 9);
        applyStimulus("restart_mul", 1, 0, 32'd3, 32'd5, 32'd15, 0, 32, 1'b1, k2);
        checkOutput("restart_edge", k2, k + 10);
        waitDrain(200);

        // A start landing in the DONE cycle still lets the finishing result pulse
        applyStimulus("done_mul", 1, 0, 32'd3, 32'd5, 32'd15, 0, 32, 1'b1, k);
        waitToCyc(k + 32);
        applyStimulus("done_div", 0, 1, 32'd100, 32'd7, 32'd14, 0, 35, 1'b1, k2);
        waitDrain(200);

        // Asynchronous reset mid-multiply clears everything and produces no pulse
        applyStimulus("abort_mul", 1, 0, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 0, 32, 1'b0, k);
        waitToCyc(k + 5);
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        applyStimulus("post_reset_mul", 1, 0, 32'd12, 32'd12, 32'd144, 0, 32, 1'b1, k);
        waitDrain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
